lsu_wb_stage: RTL and testbench

Parametrised memory/writeback stage for the RISC-V pipeline. It succeeds the fixed-latency stage 3: instead of assuming a one-cycle dcache, it uses a valid/ready request channel and a valid response channel, stalls upstream while a memory op is in flight, and supports 32- or 64-bit data. It generates store byte masks, aligns and extends load data, selects the writeback source, and holds CSR 0x51E (tohost).

---
 rtl/lsu_wb_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_lsu_wb_stage.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: memory/writeback stage with a valid/ready dcache
// request channel, a valid-pulse response and the tohost CSR.
// Ports: in_* upstream (valid/ready), dc_req_*/dc_resp_* dcache,
// wb_* registered writeback, csr_out CSR value.
// Option LSU_MISALIGN_TRAP_EN adds misalign_trap; without it a
// misaligned address is truncated to the natural alignment.
module lsu_wb_stage #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 32,
  parameter logic [11:0] CSR_ADDR = 12'h51E
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic [DATA_W-1:0]   in_store_data,
  input  logic [DATA_W-1:0]   in_rs1,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic [ADDR_W-1:0]   dc_req_addr,
  output logic [DATA_W/8-1:0] dc_req_we,
  output logic [DATA_W-1:0]   dc_req_din,
  input  logic                dc_resp_valid,
  input  logic [DATA_W-1:0]   dc_resp_data,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic [DATA_W-1:0]   csr_out
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                misalign_trap
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [1:0] MAX_SZ = 2'(OFF_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_n;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd;
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       is_csr;
  logic       is_jump;
  logic       is_branch;
  logic       accept;
  logic       mem_go;

  logic [1:0]        sz;
  logic [3:0]        lanes;
  logic [OFF_W-1:0]  low_m;
  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] ea;
  logic [NB-1:0]     base_m;
  logic [NB-1:0]     we_n;
  logic [DATA_W-1:0] din_n;
  logic [DATA_W-1:0] pc4;

  logic [ADDR_W-1:0] req_addr;
  logic [NB-1:0]     req_we;
  logic [DATA_W-1:0] req_din;
  logic              req_load;
  logic [1:0]        ld_sz;
  logic              ld_uns;
  logic [OFF_W-1:0]  ld_off;
  logic [4:0]        ld_rd;

  logic [DATA_W-1:0] sh;
  logic [6:0]        bits;
  logic              msb;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] csr_q;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign rd  = in_inst[11:7];

  assign is_load   = (opc == 7'b0000011);
  assign is_store  = (opc == 7'b0100011);
  assign is_mem    = is_load || is_store;
  assign is_branch = (opc == 7'b1100011);
  assign is_jump   = (opc == 7'b1101111)
                  || (opc == 7'b1100111);
  assign is_csr    = (opc == 7'b1110011)
                  && (in_inst[31:20] == CSR_ADDR)
                  && (f3[1:0] == 2'b01);

  assign accept = in_valid && in_ready;

  // Access size, clamped to the data path width.
  assign sz    = (f3[1:0] > MAX_SZ) ? MAX_SZ : f3[1:0];
  assign lanes = 4'd1 << sz;
  assign low_m = OFF_W'(lanes - 4'd1);
  assign ea    = ADDR_W'(in_alu);
  assign off   = ea[OFF_W-1:0] & ~low_m;
  assign pc4   = DATA_W'(in_pc) + DATA_W'(4);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal;
  assign misal  = |(ea[OFF_W-1:0] & low_m);
  assign mem_go = is_mem && !misal;
`else
  assign mem_go = is_mem;
`endif

  always_comb begin
    base_m = '0;
    for (int i = 0; i < NB; i++) begin
      base_m[i] = (4'(i) < lanes);
    end
  end

  assign we_n  = base_m << off;
  assign din_n = in_store_data << {off, 3'b000};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && mem_go) state_n = REQ;
      REQ: begin
        if (dc_req_ready) begin
          state_n = req_load ? WAIT : IDLE;
        end
      end
      WAIT: if (dc_resp_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == IDLE);
    dc_req_valid = (state == REQ);
    dc_req_we    = dc_req_valid ? req_we : '0;
    dc_req_addr  = req_addr;
    dc_req_din   = req_din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr <= '0;
      req_we   <= '0;
      req_din  <= '0;
      req_load <= 1'b0;
      ld_sz    <= '0;
      ld_uns   <= 1'b0;
      ld_off   <= '0;
      ld_rd    <= '0;
    end else if (accept && mem_go) begin
      req_addr <= {ea[ADDR_W-1:OFF_W],
                   {OFF_W{1'b0}}};
      req_we   <= is_store ? we_n : '0;
      req_din  <= din_n;
      req_load <= is_load;
      ld_sz    <= sz;
      ld_uns   <= f3[2];
      ld_off   <= off;
      ld_rd    <= rd;
    end
  end

  assign sh   = dc_resp_data >> {ld_off, 3'b000};
  assign bits = 7'd8 << ld_sz;

  always_comb begin
    msb = 1'b0;
    unique case (1'b1)
      ld_sz == 2'd0: msb = sh[7];
      ld_sz == 2'd1: msb = sh[15];
      ld_sz == 2'd2: msb = sh[31];
      default:       msb = sh[DATA_W-1];
    endcase
  end

  always_comb begin
    ld_val = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_val[i] = (i < int'(bits)) ? sh[i]
                : (msb & ~ld_uns);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid <= (rd != 5'd0) && !is_branch;
        wb_rd    <= rd;
        // CSR swap returns the old value.
        wb_data  <= is_jump ? pc4
                  : is_csr  ? csr_q
                  : in_alu;
      end else if (state == WAIT
                   && dc_resp_valid) begin
        wb_valid <= (ld_rd != 5'd0);
        wb_rd    <= ld_rd;
        wb_data  <= ld_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csr_q <= '0;
    end else if (accept && is_csr) begin
      csr_q <= f3[2] ? DATA_W'(in_inst[19:15])
                     : in_rs1;
    end
  end

  assign csr_out = csr_q;

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= accept && is_mem && misal;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_wb_stage.sv
// tb_lsu_wb_stage: directed bench for lsu_wb_stage,
// one 32-bit and one 64-bit instance.
module tb_lsu_wb_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready;
  logic [31:0] a_in_inst, a_in_pc, a_in_alu;
  logic [31:0] a_in_sd, a_in_rs1;
  logic        a_req_valid, a_req_ready;
  logic [31:0] a_req_addr, a_req_din;
  logic [3:0]  a_req_we;
  logic        a_resp_valid;
  logic [31:0] a_resp_data;
  logic        a_wb_valid;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data, a_csr;

  logic        b_in_valid, b_in_ready;
  logic [31:0] b_in_inst, b_in_pc;
  logic [63:0] b_in_alu, b_in_sd, b_in_rs1;
  logic        b_req_valid, b_req_ready;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_din;
  logic [7:0]  b_req_we;
  logic        b_resp_valid;
  logic [63:0] b_resp_data;
  logic        b_wb_valid;
  logic [4:0]  b_wb_rd;
  logic [63:0] b_wb_data, b_csr;

`ifdef LSU_MISALIGN_TRAP_EN
  logic a_trap, b_trap;
`endif

  lsu_wb_stage #(.DATA_W(32)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inst(a_in_inst), .in_pc(a_in_pc),
    .in_alu(a_in_alu), .in_store_data(a_in_sd),
    .in_rs1(a_in_rs1),
    .dc_req_valid(a_req_valid),
    .dc_req_ready(a_req_ready),
    .dc_req_addr(a_req_addr), .dc_req_we(a_req_we),
    .dc_req_din(a_req_din),
    .dc_resp_valid(a_resp_valid),
    .dc_resp_data(a_resp_data),
    .wb_valid(a_wb_valid), .wb_rd(a_wb_rd),
    .wb_data(a_wb_data), .csr_out(a_csr)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_trap(a_trap)
`endif
  );

  lsu_wb_stage #(.DATA_W(64)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inst(b_in_inst), .in_pc(b_in_pc),
    .in_alu(b_in_alu), .in_store_data(b_in_sd),
    .in_rs1(b_in_rs1),
    .dc_req_valid(b_req_valid),
    .dc_req_ready(b_req_ready),
    .dc_req_addr(b_req_addr), .dc_req_we(b_req_we),
    .dc_req_din(b_req_din),
    .dc_resp_valid(b_resp_valid),
    .dc_resp_data(b_resp_data),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd),
    .wb_data(b_wb_data), .csr_out(b_csr)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_trap(b_trap)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "timeout");
  end

  task automatic send_a(input logic [31:0] inst,
                        input logic [31:0] alu,
                        input logic [31:0] pc);
    a_in_inst = inst; a_in_alu = alu;
    a_in_pc = pc; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
      $display("FAIL rst_in_ready got %h want 1", a_in_ready); end
    n_cmp++; if (a_req_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_req_valid got %h want 0", a_req_valid); end
    n_cmp++; if (a_req_we !== 4'h0) begin n_err++;
      $display("FAIL rst_req_we got %h want 0", a_req_we); end
    n_cmp++; if (a_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_wb_valid got %h want 0", a_wb_valid); end
    n_cmp++; if (a_wb_rd !== 5'd0) begin n_err++;
      $display("FAIL rst_wb_rd got %h want 0", a_wb_rd); end
    n_cmp++; if (a_wb_data !== 32'h0) begin n_err++;
      $display("FAIL rst_wb_data got %h want 0", a_wb_data); end
    n_cmp++; if (a_csr !== 32'h0) begin n_err++;
      $display("FAIL rst_csr got %h want 0", a_csr); end
    n_cmp++; if (b_wb_data !== 64'h0) begin n_err++;
      $display("FAIL rst_b_wb_data got %h want 0", b_wb_data); end
  endtask

  task automatic test_alu();
    send_a(32'h0000_0293, 32'h1234, 32'h0);
    n_cmp++; if (a_wb_valid !== 1'b1) begin n_err++;
      $display("FAIL addi_wb_valid got %h want 1", a_wb_valid); end
    n_cmp++; if (a_wb_rd !== 5'd5) begin n_err++;
      $display("FAIL addi_wb_rd got %0d want 5", a_wb_rd); end
    n_cmp++; if (a_wb_data !== 32'h1234) begin n_err++;
      $display("FAIL addi_wb_data got %h want 1234", a_wb_data); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++;
      $display("FAIL addi_in_ready got %h want 1", a_in_ready); end
    @(negedge clk);
    n_cmp++; if (a_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL addi_pulse got %h want 0", a_wb_valid); end
    send_a(32'h0000_00EF, 32'hDEAD_BEEF, 32'h100);
    n_cmp++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd1) begin
      n_err++;
      $display("FAIL jal_wb got v=%h rd=%0d want v=1 rd=1", a_wb_valid, a_wb_rd); end
    n_cmp++; if (a_wb_data !== 32'h104) begin n_err++;
      $display("FAIL jal_data got %h want 104", a_wb_data); end
    send_a(32'h0000_0F63, 32'h1, 32'h0);
    n_cmp++; if (a_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL branch_wb got %h want 0", a_wb_valid); end
    send_a(32'h0000_0013, 32'h5, 32'h0);
    n_cmp++; if (a_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL x0_wb got %h want 0", a_wb_valid); end
  endtask

  task automatic test_back_to_back();
    a_in_inst = 32'h0000_0393; a_in_alu = 32'h11;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_inst = 32'h0000_0413; a_in_alu = 32'h22;
    n_cmp++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd7
                 || a_wb_data !== 32'h11) begin n_err++;
      $display("FAIL b2b_first got v=%h rd=%0d d=%h want 1/7/11", a_wb_valid, a_wb_rd, a_wb_data); end
    @(negedge clk);
    a_in_valid = 1'b0;
    n_cmp++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd8
                 || a_wb_data !== 32'h22) begin n_err++;
      $display("FAIL b2b_second got v=%h rd=%0d d=%h want 1/8/22", a_wb_valid, a_wb_rd, a_wb_data); end
    @(negedge clk);
  endtask

  task automatic test_csr();
    a_in_rs1 = 32'hCAFE_0001;
    send_a(32'h51E0_1073, 32'h0, 32'h0);
    n_cmp++; if (a_csr !== 32'hCAFE_0001) begin n_err++;
      $display("FAIL csrrw got %h want cafe0001", a_csr); end
    n_cmp++; if (a_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL csrrw_wb got %h want 0", a_wb_valid); end
    send_a(32'h51E0_D073, 32'h0, 32'h0);
    n_cmp++; if (a_csr !== 32'h1) begin n_err++;
      $display("FAIL csrrwi got %h want 1", a_csr); end
    send_a(32'h51F0_F073, 32'h0, 32'h0);
    n_cmp++; if (a_csr !== 32'h1) begin n_err++;
      $display("FAIL csr_other got %h want 1", a_csr); end
  endtask

  task automatic store_a(input logic [31:0] inst,
                         input logic [31:0] alu,
                         input logic [31:0] sd,
                         input logic [3:0]  we,
                         input logic [31:0] din,
                         input logic [31:0] addr,
                         input int          stall,
                         input string       nm);
    a_in_inst = inst; a_in_alu = alu; a_in_sd = sd;
    a_req_ready = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      n_cmp++; if (a_req_valid !== 1'b1 || a_in_ready !== 1'b0
                   || a_wb_valid !== 1'b0) begin n_err++;
        $display("FAIL %s_hs[%0d] got v=%h rdy=%h wb=%h want 1/0/0", nm, i, a_req_valid, a_in_ready, a_wb_valid); end
      n_cmp++; if (a_req_we !== we) begin n_err++;
        $display("FAIL %s_we[%0d] got %b want %b", nm, i, a_req_we, we); end
      n_cmp++; if (a_req_din !== din || a_req_addr !== addr) begin
        n_err++;
        $display("FAIL %s_fields[%0d] got din=%h a=%h want %h/%h", nm, i, a_req_din, a_req_addr, din, addr); end
      if (i == stall) a_req_ready = 1'b1;
      @(negedge clk);
    end
    a_req_ready = 1'b0;
    n_cmp++; if (a_req_valid !== 1'b0 || a_in_ready !== 1'b1
                 || a_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL %s_done got v=%h rdy=%h wb=%h want 0/1/0", nm, a_req_valid, a_in_ready, a_wb_valid); end
  endtask

  task automatic load_a(input logic [31:0] inst,
                        input logic [31:0] alu,
                        input logic [31:0] resp,
                        input logic [31:0] addr,
                        input int          dly,
                        input logic [31:0] exp,
                        input string       nm);
    a_in_inst = inst; a_in_alu = alu; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    n_cmp++; if (a_req_valid !== 1'b1 || a_req_we !== 4'h0
                 || a_req_addr !== addr) begin n_err++;
      $display("FAIL %s_req got v=%h we=%h a=%h want 1/0/%h", nm, a_req_valid, a_req_we, a_req_addr, addr); end
    a_req_ready = 1'b1;
    @(negedge clk);
    a_req_ready = 1'b0;
    n_cmp++; if (a_req_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_wait got v=%h rdy=%h want 0/0", nm, a_req_valid, a_in_ready); end
    repeat (dly - 1) @(negedge clk);
    a_resp_valid = 1'b1; a_resp_data = resp;
    @(negedge clk);
    a_resp_valid = 1'b0;
    n_cmp++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd6
                 || a_in_ready !== 1'b1) begin n_err++;
      $display("FAIL %s_wb got v=%h rd=%0d rdy=%h want 1/6/1", nm, a_wb_valid, a_wb_rd, a_in_ready); end
    n_cmp++; if (a_wb_data !== exp) begin n_err++;
      $display("FAIL %s_data got %h want %h", nm, a_wb_data, exp); end
    @(negedge clk);
    n_cmp++; if (a_wb_valid !== 1'b0) begin n_err++;
      $display("FAIL %s_pulse got %h want 0", nm, a_wb_valid); end
  endtask

  task automatic store_b(input logic [31:0] inst,
                         input logic [63:0] alu,
                         input logic [63:0] sd,
                         input logic [7:0]  we,
                         input logic [63:0] din,
                         input logic [31:0] addr,
                         input string       nm);
    b_in_inst = inst; b_in_alu = alu; b_in_sd = sd;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    n_cmp++; if (b_req_valid !== 1'b1 || b_req_we !== we) begin
      n_err++;
      $display("FAIL %s_we got v=%h we=%b want 1/%b", nm, b_req_valid, b_req_we, we); end
    n_cmp++; if (b_req_din !== din || b_req_addr !== addr) begin
      n_err++;
      $display("FAIL %s_fields got din=%h a=%h want %h/%h", nm, b_req_din, b_req_addr, din, addr); end
    b_req_ready = 1'b1;
    @(negedge clk);
    b_req_ready = 1'b0;
    n_cmp++; if (b_in_ready !== 1'b1 || b_wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done got rdy=%h wb=%h want 1/0", nm, b_in_ready, b_wb_valid); end
  endtask

  task automatic load_b(input logic [31:0] inst,
                        input logic [63:0] alu,
                        input logic [63:0] resp,
                        input logic [31:0] addr,
                        input logic [63:0] exp,
                        input string       nm);
    b_in_inst = inst; b_in_alu = alu; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    n_cmp++; if (b_req_valid !== 1'b1 || b_req_addr !== addr) begin
      n_err++;
      $display("FAIL %s_req got v=%h a=%h want 1/%h", nm, b_req_valid, b_req_addr, addr); end
    b_req_ready = 1'b1;
    @(negedge clk);
    b_req_ready = 1'b0;
    @(negedge clk);
    b_resp_valid = 1'b1; b_resp_data = resp;
    @(negedge clk);
    b_resp_valid = 1'b0;
    n_cmp++; if (b_wb_valid !== 1'b1 || b_wb_data !== exp) begin
      n_err++;
      $display("FAIL %s_wb got v=%h d=%h want 1/%h", nm, b_wb_valid, b_wb_data, exp); end
  endtask

  task automatic test_store();
    store_a(32'h0000_0023, 32'h1003, 32'hAB, 4'b1000,
            32'hAB00_0000, 32'h1000, 3, "sb");
    store_a(32'h0000_2023, 32'h1004, 32'h1234_5678, 4'b1111,
            32'h1234_5678, 32'h1004, 0, "sw");
  endtask

  task automatic test_load();
    load_a(32'h0000_1303, 32'h2002, 32'h8001_0000,
           32'h2000, 2, 32'hFFFF_8001, "lh");
    load_a(32'h0000_5303, 32'h2002, 32'h8001_0000,
           32'h2000, 2, 32'h0000_8001, "lhu");
    load_a(32'h0000_0303, 32'h1001, 32'h0000_8000,
           32'h1000, 1, 32'hFFFF_FF80, "lb");
    load_a(32'h0000_4303, 32'h1001, 32'h0000_8000,
           32'h1000, 1, 32'h0000_0080, "lbu");
  endtask

  task automatic test_wide();
    load_b(32'h0000_2303, 64'h1004,
           64'hFFFF_FFFF_0000_0000, 32'h1000,
           64'hFFFF_FFFF_FFFF_FFFF, "lw64");
    load_b(32'h0000_6303, 64'h1004,
           64'hFFFF_FFFF_0000_0000, 32'h1000,
           64'h0000_0000_FFFF_FFFF, "lwu64");
    load_b(32'h0000_3303, 64'h1008,
           64'h0123_4567_89AB_CDEF, 32'h1008,
           64'h0123_4567_89AB_CDEF, "ld64");
    load_b(32'h0000_0303, 64'h1007,
           64'h8000_0000_0000_0000, 32'h1000,
           64'hFFFF_FFFF_FFFF_FF80, "lb64");
    store_b(32'h0000_3023, 64'h2000,
            64'h1122_3344_5566_7788, 8'hFF,
            64'h1122_3344_5566_7788, 32'h2000, "sd64");
    store_b(32'h0000_2023, 64'h2004,
            64'h0000_0000_DEAD_BEEF, 8'hF0,
            64'hDEAD_BEEF_0000_0000, 32'h2000, "sw64");
  endtask

  task automatic test_misalign();
    send_a(32'h51E0_D073, 32'h0, 32'h0);
    n_cmp++; if (a_csr !== 32'h1) begin n_err++;
      $display("FAIL mis_csr got %h want 1", a_csr); end
`ifdef LSU_MISALIGN_TRAP_EN
    send_a(32'h0000_2303, 32'h1001, 32'h0);
    n_cmp++; if (a_trap !== 1'b1 || a_wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mis_trap got t=%h wb=%h want 1/0", a_trap, a_wb_valid); end
    n_cmp++; if (a_req_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mis_noreq got v=%h rdy=%h want 0/1", a_req_valid, a_in_ready); end
    @(negedge clk);
    n_cmp++; if (a_trap !== 1'b0 || a_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mis_pulse got t=%h v=%h want 0/0", a_trap, a_req_valid); end
`else
    load_a(32'h0000_2303, 32'h1001, 32'h1122_3344,
           32'h1000, 1, 32'h1122_3344, "mis_lw");
    store_a(32'h0000_1023, 32'h1003, 32'h5A5A, 4'b1100,
            32'h5A5A_0000, 32'h1000, 0, "mis_sh");
`endif
  endtask

  task automatic test_reset_wait();
    a_in_inst = 32'h0000_2303; a_in_alu = 32'h3000;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_req_ready = 1'b1;
    @(negedge clk);
    a_req_ready = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++;
      $display("FAIL rw_inwait got %h want 0", a_in_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1 || a_csr !== 32'h0
                 || a_req_valid !== 1'b0) begin n_err++;
      $display("FAIL rw_async got rdy=%h csr=%h v=%h want 1/0/0", a_in_ready, a_csr, a_req_valid); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    a_resp_valid = 1'b1; a_resp_data = 32'h5555_5555;
    @(negedge clk);
    a_resp_valid = 1'b0;
    n_cmp++; if (a_wb_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rw_late got wb=%h rdy=%h want 0/1", a_wb_valid, a_in_ready); end
    n_cmp++; if (a_csr !== 32'h0) begin n_err++;
      $display("FAIL rw_csr got %h want 0", a_csr); end
  endtask

  initial begin
    a_in_valid = 0; a_in_inst = 0; a_in_pc = 0;
    a_in_alu = 0; a_in_sd = 0; a_in_rs1 = 0;
    a_req_ready = 0; a_resp_valid = 0; a_resp_data = 0;
    b_in_valid = 0; b_in_inst = 0; b_in_pc = 0;
    b_in_alu = 0; b_in_sd = 0; b_in_rs1 = 0;
    b_req_ready = 0; b_resp_valid = 0; b_resp_data = 0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_alu();
    test_back_to_back();
    test_csr();
    test_store();
    test_load();
    test_wide();
    test_misalign();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
